// File: rtl/rv64g_l1_vlsu_miss_collect.sv
`default_nettype none
// ============================================================================
// Module   : rv64g_l1_vlsu_miss_collect
// Purpose  : Collects one vector access's lane misses and issues one serial
//            line-fill per unique 64B line, then reports the replay mask.
// Revision : 1.0 - initial release
// ============================================================================
module rv64g_l1_vlsu_miss_collect #(
    parameter int NUM_LANES  = 8,
    parameter int LINE_OFF_W = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cap_valid_i,
    output logic                       cap_ready_o,
    input  logic [NUM_LANES*64-1:0]    lane_addr_i,
    input  logic [NUM_LANES-1:0]       lane_miss_i,
    input  logic [NUM_LANES-1:0]       lane_store_i,
    output logic                       fill_req_valid_o,
    input  logic                       fill_req_ready_i,
    output logic [64-LINE_OFF_W-1:0]   fill_req_addr_o,
    output logic                       fill_req_excl_o,
    output logic [NUM_LANES-1:0]       fill_req_lanes_o,
    input  logic                       fill_done_i,
    output logic                       done_o,
    output logic [NUM_LANES-1:0]       replay_mask_o,
    output logic                       busy_o,
    output logic [3:0]                 fill_cnt_o
);

    localparam int LINE_W = 64 - LINE_OFF_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_FILL = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]                          state_q, state_d;
    logic [NUM_LANES-1:0]                pending_q, pending_d;
    logic [NUM_LANES-1:0]                store_q, store_d;
    logic [NUM_LANES-1:0]                replay_q, replay_d;
    logic [NUM_LANES-1:0][LINE_W-1:0]    line_q, line_d;
    logic [3:0]                          cnt_q, cnt_d;

    logic [NUM_LANES-1:0][LINE_W-1:0]    w_cap_line;
    logic [NUM_LANES*LINE_OFF_W-1:0]     w_unused_off;
    logic [LINE_W-1:0]                   w_lead_line;
    logic                                w_lead_found;
    logic [NUM_LANES-1:0]                w_group;
    logic                                w_issue;
    logic                                w_fire;

    // Only the line address of each lane matters; byte offsets are dropped.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign w_cap_line[l] = lane_addr_i[(l+1)*64-1 -: LINE_W];
        assign w_unused_off[l*LINE_OFF_W +: LINE_OFF_W] = lane_addr_i[l*64 +: LINE_OFF_W];
    end

    // Lead is the lowest pending lane; its line defines the merge group.
    always_comb begin
        w_lead_found = 1'b0;
        w_lead_line  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (pending_q[l] && !w_lead_found) begin
                w_lead_found = 1'b1;
                w_lead_line  = line_q[l];
            end
        end
        w_group = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_group[l] = pending_q[l] && (line_q[l] == w_lead_line);
        end
    end

    assign w_issue = (state_q == S_ISSUE);
    assign w_fire  = w_issue && fill_req_ready_i;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        store_d   = store_q;
        replay_d  = replay_q;
        line_d    = line_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cap_valid_i) begin
                    line_d    = w_cap_line;
                    store_d   = lane_store_i;
                    pending_d = lane_miss_i;
                    replay_d  = lane_miss_i;
                    cnt_d     = 4'd0;
                    state_d   = (lane_miss_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_fire) begin
                    pending_d = pending_q & ~w_group;
                    cnt_d     = cnt_q + 4'd1;
                    state_d   = S_WAIT_FILL;
                end
            end
            S_WAIT_FILL: begin
                if (fill_done_i) begin
                    state_d = (pending_q != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            store_q   <= '0;
            replay_q  <= '0;
            line_q    <= '0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            store_q   <= store_d;
            replay_q  <= replay_d;
            line_q    <= line_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cap_ready_o      = (state_q == S_IDLE);
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE);
    assign fill_req_valid_o = w_issue;
    assign fill_req_addr_o  = w_issue ? w_lead_line : '0;
    assign fill_req_lanes_o = w_issue ? w_group : '0;
    assign fill_req_excl_o  = w_issue && |(w_group & store_q);
    assign replay_mask_o    = replay_q;
    assign fill_cnt_o       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rv64g_l1_vlsu_miss_collect.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv64g_l1_vlsu_miss_collect
// Purpose  : Randomized and directed checks against a line-dedup reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv64g_l1_vlsu_miss_collect;

    localparam int N   = 8;
    localparam int OFF = 6;
    localparam int LW  = 64 - OFF;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            cap_valid_i = 1'b0;
    logic            cap_ready_o;
    logic [N*64-1:0] lane_addr_i = '0;
    logic [N-1:0]    lane_miss_i = '0;
    logic [N-1:0]    lane_store_i = '0;
    logic            fill_req_valid_o;
    logic            fill_req_ready_i = 1'b0;
    logic [LW-1:0]   fill_req_addr_o;
    logic            fill_req_excl_o;
    logic [N-1:0]    fill_req_lanes_o;
    logic            fill_done_i = 1'b0;
    logic            done_o;
    logic [N-1:0]    replay_mask_o;
    logic            busy_o;
    logic [3:0]      fill_cnt_o;

    int vec = 0;
    int err = 0;

    // Reference: requests in order of first appearance of each distinct line.
    logic [LW-1:0] m_line[$];
    logic [N-1:0]  m_lanes[$];
    logic          m_excl[$];

    rv64g_l1_vlsu_miss_collect #(.NUM_LANES(N), .LINE_OFF_W(OFF)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cap_valid_i(cap_valid_i), .cap_ready_o(cap_ready_o),
        .lane_addr_i(lane_addr_i), .lane_miss_i(lane_miss_i), .lane_store_i(lane_store_i),
        .fill_req_valid_o(fill_req_valid_o), .fill_req_ready_i(fill_req_ready_i),
        .fill_req_addr_o(fill_req_addr_o), .fill_req_excl_o(fill_req_excl_o),
        .fill_req_lanes_o(fill_req_lanes_o), .fill_done_i(fill_done_i),
        .done_o(done_o), .replay_mask_o(replay_mask_o), .busy_o(busy_o),
        .fill_cnt_o(fill_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void build_model(input logic [N*64-1:0] a, input logic [N-1:0] m,
                                        input logic [N-1:0] s);
        m_line.delete(); m_lanes.delete(); m_excl.delete();
        for (int l = 0; l < N; l++) begin
            if (m[l]) begin
                logic [63:0]   addr;
                logic [LW-1:0] line;
                int            hit;
                addr = a[l*64 +: 64];
                line = addr[63:OFF];
                hit  = -1;
                for (int k = 0; k < m_line.size(); k++) if (m_line[k] == line) hit = k;
                if (hit < 0) begin
                    m_line.push_back(line);
                    m_lanes.push_back(N'(1) << l);
                    m_excl.push_back(s[l]);
                end else begin
                    logic [N-1:0] t;
                    t = m_lanes[hit]; t[l] = 1'b1; m_lanes[hit] = t;
                    if (s[l]) m_excl[hit] = 1'b1;
                end
            end
        end
    endfunction

    task automatic scramble_inputs();
        for (int l = 0; l < N; l++) lane_addr_i[l*64 +: 64] = {$urandom, $urandom};
        lane_miss_i  = N'($urandom);
        lane_store_i = N'($urandom);
    endtask

    task automatic do_access(input string tag, input logic [N*64-1:0] a, input logic [N-1:0] m,
                             input logic [N-1:0] s, input int rdy_wait, input bit inject);
        int nreq;
        build_model(a, m, s);
        nreq = m_line.size();
        @(negedge clk_i);
        vec++;
        if (cap_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            err++; $display("FAIL %s idle: cap_ready=%b busy=%b, want 1 0", tag, cap_ready_o, busy_o);
        end
        cap_valid_i = 1'b1; lane_addr_i = a; lane_miss_i = m; lane_store_i = s;
        @(negedge clk_i);
        cap_valid_i = 1'b0;
        scramble_inputs();
        for (int i = 0; i < nreq; i++) begin
            vec++;
            if (fill_req_valid_o !== 1'b1 || fill_req_addr_o !== m_line[i] ||
                fill_req_lanes_o !== m_lanes[i] || fill_req_excl_o !== m_excl[i] ||
                fill_cnt_o !== 4'(i) || busy_o !== 1'b1) begin
                err++;
                $display("FAIL %s req%0d: got v=%b addr=%h lanes=%h excl=%b cnt=%0d, want v=1 addr=%h lanes=%h excl=%b cnt=%0d",
                         tag, i, fill_req_valid_o, fill_req_addr_o, fill_req_lanes_o, fill_req_excl_o,
                         fill_cnt_o, m_line[i], m_lanes[i], m_excl[i], i);
            end
            fill_req_ready_i = 1'b0;
            for (int k = 0; k < rdy_wait; k++) begin
                if (inject && k == 0) begin
                    fill_done_i = 1'b1; cap_valid_i = 1'b1; lane_miss_i = ~m;
                end
                @(negedge clk_i);
                fill_done_i = 1'b0; cap_valid_i = 1'b0;
                vec++;
                if (fill_req_valid_o !== 1'b1 || fill_req_addr_o !== m_line[i] ||
                    fill_req_lanes_o !== m_lanes[i] || fill_req_excl_o !== m_excl[i]) begin
                    err++;
                    $display("FAIL %s stall%0d.%0d: got v=%b addr=%h lanes=%h excl=%b, want v=1 addr=%h lanes=%h excl=%b",
                             tag, i, k, fill_req_valid_o, fill_req_addr_o, fill_req_lanes_o,
                             fill_req_excl_o, m_line[i], m_lanes[i], m_excl[i]);
                end
            end
            fill_req_ready_i = 1'b1;
            @(negedge clk_i);
            fill_req_ready_i = 1'b0;
            vec++;
            if (fill_req_valid_o !== 1'b0 || fill_req_addr_o !== '0 || fill_req_lanes_o !== '0 ||
                fill_req_excl_o !== 1'b0 || fill_cnt_o !== 4'(i+1) || done_o !== 1'b0) begin
                err++;
                $display("FAIL %s wait%0d: got v=%b addr=%h lanes=%h excl=%b cnt=%0d done=%b, want 0 0 0 0 %0d 0",
                         tag, i, fill_req_valid_o, fill_req_addr_o, fill_req_lanes_o,
                         fill_req_excl_o, fill_cnt_o, done_o, i+1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            fill_done_i = 1'b1;
            @(negedge clk_i);
            fill_done_i = 1'b0;
        end
        vec++;
        if (done_o !== 1'b1 || replay_mask_o !== m || fill_cnt_o !== 4'(nreq) ||
            fill_req_valid_o !== 1'b0) begin
            err++;
            $display("FAIL %s done: got done=%b replay=%h cnt=%0d v=%b, want 1 %h %0d 0",
                     tag, done_o, replay_mask_o, fill_cnt_o, fill_req_valid_o, m, nreq);
        end
        @(negedge clk_i);
        vec++;
        if (done_o !== 1'b0 || cap_ready_o !== 1'b1 || busy_o !== 1'b0 ||
            replay_mask_o !== m || fill_cnt_o !== 4'(nreq)) begin
            err++;
            $display("FAIL %s post: got done=%b ready=%b busy=%b replay=%h cnt=%0d, want 0 1 0 %h %0d",
                     tag, done_o, cap_ready_o, busy_o, replay_mask_o, fill_cnt_o, m, nreq);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        vec++;
        if (cap_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || fill_req_valid_o !== 1'b0 ||
            replay_mask_o !== '0 || fill_cnt_o !== 4'd0 || fill_req_lanes_o !== '0) begin
            err++;
            $display("FAIL reset: got ready=%b busy=%b done=%b v=%b replay=%h cnt=%0d lanes=%h, want 1 0 0 0 0 0 0",
                     cap_ready_o, busy_o, done_o, fill_req_valid_o, replay_mask_o, fill_cnt_o, fill_req_lanes_o);
        end
    endtask

    task automatic test_no_miss();
        logic [N*64-1:0] a;
        for (int l = 0; l < N; l++) a[l*64 +: 64] = {$urandom, $urandom};
        do_access("no_miss", a, '0, N'($urandom), 0, 1'b0);
    endtask

    task automatic test_merge_same_line();
        logic [N*64-1:0] a;
        a = '0;
        a[0*64 +: 64] = 64'h1000;
        a[2*64 +: 64] = 64'h1038;
        do_access("merge", a, 8'b0000_0101, '0, 1, 1'b0);
    endtask

    task automatic test_all_distinct();
        logic [N*64-1:0] a;
        for (int l = 0; l < N; l++) a[l*64 +: 64] = 64'(l * 64'h40);
        do_access("distinct", a, 8'hFF, 8'h00, 0, 1'b0);
    endtask

    task automatic test_excl();
        logic [N*64-1:0] a;
        for (int l = 0; l < N; l++) a[l*64 +: 64] = {$urandom, $urandom};
        a[1*64 +: 64] = 64'h8000_0000_0000_2008;
        a[3*64 +: 64] = 64'h8000_0000_0000_2030;
        do_access("excl_st", a, 8'h0A, 8'h08, 0, 1'b0);
        do_access("excl_ld", a, 8'h0A, 8'h00, 0, 1'b0);
    endtask

    task automatic test_stall_ignore();
        logic [N*64-1:0] a;
        for (int l = 0; l < N; l++) a[l*64 +: 64] = {$urandom, $urandom};
        do_access("stall", a, 8'h81, 8'h01, 5, 1'b1);
    endtask

    task automatic test_random();
        logic [LW-1:0] pool [4];
        pool[0] = 58'h40;
        pool[1] = 58'h41;
        pool[2] = 58'h40 | (58'h1 << 40);
        pool[3] = 58'h2_1234_5678;
        for (int it = 0; it < 20; it++) begin
            logic [N*64-1:0] a;
            for (int l = 0; l < N; l++)
                a[l*64 +: 64] = {pool[$urandom_range(0, 3)], 6'($urandom)};
            do_access("random", a, N'($urandom), N'($urandom), $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk_i);
        cap_valid_i = 1'b1; lane_miss_i = 8'h01; lane_addr_i = '0; lane_store_i = '0;
        @(negedge clk_i);
        cap_valid_i = 1'b0; fill_req_ready_i = 1'b1;
        @(negedge clk_i);
        fill_req_ready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        vec++;
        if (fill_req_valid_o !== 1'b0 || busy_o !== 1'b0 || cap_ready_o !== 1'b1 ||
            replay_mask_o !== '0 || fill_cnt_o !== 4'd0 || done_o !== 1'b0) begin
            err++;
            $display("FAIL rst_mid: got v=%b busy=%b ready=%b replay=%h cnt=%0d done=%b, want 0 0 1 0 0 0",
                     fill_req_valid_o, busy_o, cap_ready_o, replay_mask_o, fill_cnt_o, done_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        fill_done_i = 1'b1;
        @(negedge clk_i);
        fill_done_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || cap_ready_o !== 1'b1) begin
                err++;
                $display("FAIL rst_after%0d: got done=%b busy=%b ready=%b, want 0 0 1",
                         k, done_o, busy_o, cap_ready_o);
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        test_reset();
        test_no_miss();
        test_merge_same_line();
        test_all_distinct();
        test_excl();
        test_stall_ignore();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
